mem_stage_access: RTL

Memory-stage access sequencer that sits directly downstream of the EX/MEM pipeline register and consumes its outputs. It turns the registered `Mem` control bits, ALU result and rt data into a request/acknowledge transaction on a variable-latency data memory. While an access is outstanding it stalls the pipeline, then presents the load data and branch decision to the MEM/WB side.

---
 rtl/mem_stage_access_if.sv | 20 ++
 rtl/mem_stage_access.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_if.sv
// mem_stage_access_if: request/acknowledge bus between the memory-stage
// sequencer (master) and a variable-latency data memory (slave).
interface mem_stage_access_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage_access.sv
// mem_stage_access: memory-stage access sequencer fed by the EX/MEM register.
// Turns Mem control bits into a req/ack transaction on the data memory bus,
// stalls the pipeline while the access is outstanding and abandons it after
// TIMEOUT_CYCLES wait cycles without an ack.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned access trap and the
// misalign_o port). Without it, the address is truncated to a word boundary.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access outstanding; a present access is latched here
// WAIT  | request held on the bus, counting cycles until ack or timeout
// DONE  | pipeline released for one cycle; result pulses are visible
module mem_stage_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  mem_ctrl_i,
  input  logic        zero_i,
  input  logic [31:0] alu_ans_i,
  input  logic [31:0] rtdata_i,
  mem_stage_access_if.master dmem,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        branch_taken_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [7:0]  count_q;
  logic [7:0]  count_inc;
  logic        is_branch;
  logic        is_read;
  logic        is_write;
  logic        access;
  logic        misaligned;
  logic [31:0] addr_next;

  // mem_ctrl_i is {Branch, MemRead, MemWrite}; write takes priority over read
  assign is_branch = mem_ctrl_i[2];
  assign is_read   = mem_ctrl_i[1];
  assign is_write  = mem_ctrl_i[0];
  assign access    = is_read | is_write;
  assign count_inc = count_q + 8'd1;

  assign branch_taken_o = is_branch & zero_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (alu_ans_i[1:0] != 2'b00);
  assign addr_next  = alu_ans_i;
`else
  // Byte offset is dropped: the memory is only ever addressed by word
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^alu_ans_i[1:0];
  assign misaligned      = 1'b0;
  assign addr_next       = {alu_ans_i[31:2], 2'b00};
`endif

  // Stall is combinational so the pipeline freezes in the same cycle the access appears
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: stall_o = access;
        ST_WAIT: stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  // Sequencer state, bus outputs and result pulses, all registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= ST_IDLE;
      count_q            <= '0;
      dmem.dmem_req_o    <= 1'b0;
      dmem.dmem_we_o     <= 1'b0;
      dmem.dmem_addr_o   <= '0;
      dmem.dmem_wdata_o  <= '0;
      rdata_o            <= '0;
      rdata_valid_o      <= 1'b0;
      timeout_o          <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o         <= 1'b0;
`endif
    end else begin
      rdata_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o    <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            if (misaligned) begin
              // Trapped without touching the bus; loads return zero
              state_q <= ST_DONE;
`ifdef MEM_ALIGN_CHECK_EN
              misalign_o <= 1'b1;
`endif
              if (!is_write) rdata_o <= '0;
            end else begin
              state_q           <= ST_WAIT;
              count_q           <= '0;
              dmem.dmem_req_o   <= 1'b1;
              dmem.dmem_we_o    <= is_write;
              dmem.dmem_addr_o  <= addr_next;
              dmem.dmem_wdata_o <= is_write ? rtdata_i : 32'd0;
            end
          end
        end
        ST_WAIT: begin
          // Ack is checked first so it wins over a simultaneous timeout
          if (dmem.dmem_ack_i) begin
            state_q         <= ST_DONE;
            dmem.dmem_req_o <= 1'b0;
            count_q         <= count_inc;
            if (!dmem.dmem_we_o) begin
              rdata_o       <= dmem.dmem_rdata_i;
              rdata_valid_o <= 1'b1;
            end
          end else if (count_inc == TIMEOUT_LIM) begin
            state_q         <= ST_DONE;
            dmem.dmem_req_o <= 1'b0;
            count_q         <= count_inc;
            timeout_o       <= 1'b1;
            if (!dmem.dmem_we_o) rdata_o <= '0;
          end else begin
            count_q <= count_inc;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule
